multiword_add_sequencer: RTL and testbench

MULTIWORD_ADD_SEQUENCER -- requirements
Module: multiword_add_sequencer

---
 rtl/multiword_add_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_multiword_add_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer
//   Adds (or, with MULTIWORD_SUB_EN defined, subtracts) two NWORDS x 32-bit
//   operands. The design uses a single 32-bit carry_bypass_adder, one word per
//   clock, starting at the least significant word.
//
// Configuration macro: MULTIWORD_SUB_EN
//   When defined, op_sub=1 gives A-B. The B words are inverted and the word-0
//   carry is forced to 1. When not defined, op_sub is latched only for the
//   debug output, and every operation is an add.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   start             request; accepted only in IDLE
//   op_sub, cin       operation select and carry-in, sampled with start
//   op_a, op_b        operands, word 0 = least significant
//   result            registered sum/difference (32*NWORDS)
//   cout, overflow    carry out / signed overflow of the full-width result
//   busy              high in RUN and DONE
//   done              one-cycle pulse when result is valid
//   dbg_state_o       current FSM state (IDLE=0, RUN=1, DONE=2)
//   dbg_sub_o         latched operation select of the current/last operation
//
// Handshake: start is a request-only pulse/level. It is taken on the first
// rising edge in IDLE where start=1. It is ignored in RUN and DONE, and no
// request is queued. done marks the cycle where result/cout/overflow first
// hold the new value. Those outputs then hold until the next accepted
// operation overwrites them.

module carry_bypass_adder (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Cin,
  output logic [31:0] Sum,
  output logic        Cout,
  output logic        Overflow
);
  logic [31:0] p;
  logic [8:0]  blk_c;
  logic        rip;
  logic        c31;

  // 4-bit blocks. When every bit of a block propagates, the block carry-in
  // skips straight to the next block.
  always_comb begin
    p     = A ^ B;
    Sum   = '0;
    blk_c = '0;
    rip   = 1'b0;
    c31   = 1'b0;
    blk_c[0] = Cin;
    for (int k = 0; k < 8; k++) begin
      rip = blk_c[k];
      for (int i = 0; i < 4; i++) begin
        if (k == 7 && i == 3) c31 = rip;
        Sum[k*4+i] = p[k*4+i] ^ rip;
        rip = (A[k*4+i] & B[k*4+i]) | (p[k*4+i] & rip);
      end
      blk_c[k+1] = (&p[k*4 +: 4]) ? blk_c[k] : rip;
    end
    Cout     = blk_c[8];
    Overflow = c31 ^ blk_c[8];
  end
endmodule

module multiword_add_sequencer #(
  parameter int NWORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 op_sub,
  input  logic                 cin,
  input  logic [32*NWORDS-1:0] op_a,
  input  logic [32*NWORDS-1:0] op_b,
  output logic [32*NWORDS-1:0] result,
  output logic                 cout,
  output logic                 overflow,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           dbg_state_o,
  output logic                 dbg_sub_o
);
  localparam int W    = 32 * NWORDS;
  localparam int IDXW = $clog2(NWORDS);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t          state_q;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q;
  logic [W-1:0]    a_q, b_q;
  logic            sub_q, cin_q;
  logic [W-1:0]    result_q, result_d;
  logic            cout_q, ovf_q, busy_q, done_q;

  logic [31:0]     word_a, word_b, add_b, add_sum;
  logic            first_c, add_cin, add_cout, add_ovf;
  logic            last_word;

  // Select the operand words for the current index.
  always_comb begin
    word_a = '0;
    word_b = '0;
    for (int w = 0; w < NWORDS; w++) begin
      if (idx_q == IDXW'(w)) begin
        word_a = a_q[w*32 +: 32];
        word_b = b_q[w*32 +: 32];
      end
    end
  end

`ifdef MULTIWORD_SUB_EN
  // Two's complement subtract: A + ~B + 1. cout=1 then means no borrow.
  assign add_b   = sub_q ? ~word_b : word_b;
  assign first_c = sub_q ? 1'b1 : cin_q;
`else
  assign add_b   = word_b;
  assign first_c = cin_q;
`endif

  assign add_cin   = (idx_q == '0) ? first_c : carry_q;
  assign last_word = (idx_q == IDXW'(NWORDS - 1));
  assign idx_d     = idx_q + 1'b1;

  carry_bypass_adder u_adder (
    .A        (word_a),
    .B        (add_b),
    .Cin      (add_cin),
    .Sum      (add_sum),
    .Cout     (add_cout),
    .Overflow (add_ovf)
  );

  // Only the word at the current index changes. The other words keep their
  // old value until their own turn.
  always_comb begin
    result_d = result_q;
    for (int w = 0; w < NWORDS; w++) begin
      if (idx_q == IDXW'(w)) result_d[w*32 +: 32] = add_sum;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      cin_q    <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= op_a;
            b_q     <= op_b;
            sub_q   <= op_sub;
            cin_q   <= cin;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          result_q <= result_d;
          carry_q  <= add_cout;
          idx_q    <= idx_d;
          if (last_word) begin
            cout_q  <= add_cout;
            ovf_q   <= add_ovf;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign result      = result_q;
  assign cout        = cout_q;
  assign overflow    = ovf_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign dbg_state_o = state_q;
  assign dbg_sub_o   = sub_q;
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Bench for multiword_add_sequencer (NWORDS=4, 128-bit operands).
module tb_multiword_add_sequencer;
  localparam int NW = 4;
  localparam int W  = 32 * NW;
`ifdef MULTIWORD_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         op_sub = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic [W-1:0] result;
  logic         cout, overflow, busy, done;
  logic [1:0]   dbg_state_o;
  logic         dbg_sub_o;

  int errors = 0;
  int checks = 0;

  multiword_add_sequencer #(.NWORDS(NW)) dut (
    .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .cin(cin),
    .op_a(op_a), .op_b(op_b), .result(result), .cout(cout),
    .overflow(overflow), .busy(busy), .done(done),
    .dbg_state_o(dbg_state_o), .dbg_sub_o(dbg_sub_o)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic signed [W+1:0] sext(input logic [W-1:0] v);
    return $signed({{2{v[W-1]}}, v});
  endfunction

  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input logic c,
                       output logic [W-1:0] r, output logic co, output logic ov);
    logic [W:0]            u;
    logic signed [W+1:0]   s;
    if (sub && SUB_EN) begin
      u  = {1'b0, a} - {1'b0, b};
      co = (a >= b);
      s  = sext(a) - sext(b);
    end else begin
      u  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      co = u[W];
      s  = sext(a) + sext(b) + $signed({{(W+1){1'b0}}, c});
    end
    r  = u[W-1:0];
    ov = (s > sext({1'b0, {(W-1){1'b1}}})) || (s < sext({1'b1, {(W-1){1'b0}}}));
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] v;
    for (int i = 0; i < NW; i++) v[i*32 +: 32] = $urandom;
    case ($urandom_range(0, 7))
      0: v = '1;
      1: v = '0;
      2: v = {1'b0, {(W-1){1'b1}}};
      default: ;
    endcase
    return v;
  endfunction

  // ---------------- driver ----------------
  // Issues one operation and reports how many edges after the start edge
  // done was seen (-1 if never within the bound).
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input logic c, output int lat);
    @(posedge clk); #1;
    op_a = a; op_b = b; op_sub = sub; cin = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op_a = rand_word(); op_b = rand_word();
    op_sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    op_a = rand_word(); op_b = rand_word(); start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (result !== '0) begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
    checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b exp=0", cout); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
  endtask

  task automatic test_directed_add();
    logic [W-1:0] va [3];
    logic [W-1:0] vb [3];
    logic         vc [3];
    logic [W-1:0] er [3];
    logic         ec [3];
    logic         eo [3];
    int lat;
    va[0] = {W{1'b1}};                             vb[0] = 128'h1; vc[0] = 1'b0;
    er[0] = '0;                                    ec[0] = 1'b1;   eo[0] = 1'b0;
    va[1] = 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF; vb[1] = 128'h1; vc[1] = 1'b0;
    er[1] = 128'h8000_0000_0000_0000_0000_0000_0000_0000; ec[1] = 1'b0;   eo[1] = 1'b1;
    va[2] = 128'h0000_0001_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF; vb[2] = '0;    vc[2] = 1'b1;
    er[2] = 128'h0000_0002_0000_0000_0000_0000_0000_0000; ec[2] = 1'b0;   eo[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_op(va[i], vb[i], 1'b0, vc[i], lat);
      checks++; if (lat != NW) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, NW); end
      checks++; if (result !== er[i]) begin errors++; $display("FAIL dir%0d_result got=%h exp=%h", i, result, er[i]); end
      checks++; if (cout !== ec[i]) begin errors++; $display("FAIL dir%0d_cout got=%b exp=%b", i, cout, ec[i]); end
      checks++; if (overflow !== eo[i]) begin errors++; $display("FAIL dir%0d_ovf got=%b exp=%b", i, overflow, eo[i]); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL dir%0d_after_done done=%b busy=%b exp 0/0", i, done, busy); end
    end
  endtask

  task automatic test_directed_sub();
`ifdef MULTIWORD_SUB_EN
    int lat;
    do_op('0, 128'h1, 1'b1, 1'b0, lat);
    checks++; if (result !== {W{1'b1}} || cout !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL sub0 got r=%h c=%b o=%b exp r=all-ones c=0 o=0", result, cout, overflow);
    end
    do_op(128'h8000_0000_0000_0000_0000_0000_0000_0000, 128'h1, 1'b1, 1'b1, lat);
    checks++; if (result !== 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF || overflow !== 1'b1 || cout !== 1'b1) begin
      errors++; $display("FAIL sub1 got r=%h c=%b o=%b exp r=7fff..ffff c=1 o=1", result, cout, overflow);
    end
`endif
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, er;
    logic s, c, ec, eo;
    int lat;
    for (int i = 0; i < 24; i++) begin
      a = rand_word(); b = rand_word();
      s = 1'($urandom_range(0, 1)); c = 1'($urandom_range(0, 1));
      model(a, b, s, c, er, ec, eo);
      do_op(a, b, s, c, lat);
      checks++; if (lat != NW) begin errors++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, NW); end
      checks++; if (result !== er) begin errors++; $display("FAIL rnd%0d_result got=%h exp=%h", i, result, er); end
      checks++; if (cout !== ec) begin errors++; $display("FAIL rnd%0d_cout got=%b exp=%b", i, cout, ec); end
      checks++; if (overflow !== eo) begin errors++; $display("FAIL rnd%0d_ovf got=%b exp=%b", i, overflow, eo); end
    end
  endtask

  task automatic test_start_while_busy();
    logic [W-1:0] a, b, er;
    logic ec, eo;
    int dones;
    a = rand_word(); b = rand_word();
    model(a, b, 1'b0, 1'b1, er, ec, eo);
    @(posedge clk); #1;
    op_a = a; op_b = b; op_sub = 1'b0; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    op_a = rand_word(); op_b = rand_word(); op_sub = 1'b1; cin = 1'b0;
    dones = 0;
    for (int k = 1; k <= NW + 1; k++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_ignore_done_cycle busy=%b exp=0", busy); end
    start = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    checks++; if (dones != 1) begin errors++; $display("FAIL busy_ignore_dones got=%0d exp=1", dones); end
    checks++; if (result !== er || cout !== ec || overflow !== eo) begin
      errors++; $display("FAIL busy_ignore_result got=%h/%b/%b exp=%h/%b/%b", result, cout, overflow, er, ec, eo);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a1, b1, r1, a2, b2, r2;
    logic c1, o1, c2, o2;
    int lat;
    a1 = rand_word(); b1 = rand_word(); a2 = rand_word(); b2 = rand_word();
    model(a1, b1, 1'b0, 1'b0, r1, c1, o1);
    model(a2, b2, 1'b0, 1'b1, r2, c2, o2);
    @(posedge clk); #1;
    op_a = a1; op_b = b1; op_sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
    checks++; if (lat != NW) begin errors++; $display("FAIL b2b_first_latency got=%0d exp=%0d", lat, NW); end
    // Request during the DONE cycle; it is ignored there and taken one cycle later.
    op_a = a2; op_b = b2; op_sub = 1'b0; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || result !== r1) begin
      errors++; $display("FAIL b2b_hold busy=%b result=%h exp busy=0 result=%h", busy, result, r1);
    end
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept busy=%b exp=1", busy); end
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
    checks++; if (lat != NW) begin errors++; $display("FAIL b2b_second_latency got=%0d exp=%0d", lat, NW); end
    checks++; if (result !== r2 || cout !== c2 || overflow !== o2) begin
      errors++; $display("FAIL b2b_second_result got=%h/%b/%b exp=%h/%b/%b", result, cout, overflow, r2, c2, o2);
    end
  endtask

  task automatic test_reset_abort();
    int dones;
    @(posedge clk); #1;
    op_a = rand_word(); op_b = rand_word(); op_sub = 1'b0; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++; if (result !== '0 || cout !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_outputs r=%h c=%b o=%b busy=%b done=%b exp all 0", result, cout, overflow, busy, done);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 2 * NW; k++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    checks++; if (dones != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_no_done dones=%0d busy=%b exp 0/0", dones, busy);
    end
  endtask

  initial begin
    test_reset();
    test_directed_add();
    test_directed_sub();
    test_random();
    test_start_while_busy();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
